// File: rtl/adder_disp_pkg.sv
// Shared constants and types for the adder result display.
// Contents: value/digit/segment/anode widths, seven-segment glyphs
// ({g,f,e,d,c,b,a}, active-high), digit-enable patterns, digit FSM enum,
// packed BCD pair and a binary-to-BCD helper for values 0..15.
package adder_disp_pkg;

  localparam int unsigned VAL_W = 4;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 2;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  localparam logic [AN_W-1:0] AN_ONES = 2'b01;
  localparam logic [AN_W-1:0] AN_TENS = 2'b10;
  localparam logic [AN_W-1:0] AN_NONE = 2'b00;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_e;

  typedef struct packed {
    logic             tens;
    logic [DIG_W-1:0] ones;
  } bcd_t;

  // Two-digit split; 15 is outside the adder's range but still splits as 1/5.
  function automatic bcd_t to_bcd(input logic [VAL_W-1:0] v);
    bcd_t r;
    r.tens = (v >= VAL_W'(10));
    r.ones = r.tens ? DIG_W'(v - VAL_W'(10)) : DIG_W'(v);
    return r;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational decimal digit to seven-segment glyph.
// Ports: digit (4b, 0..9 meaningful), seg_c (7b {g,f,e,d,c,b,a}, active-high;
// blank for digits above 9).
module seg7_encode
  import adder_disp_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (digit)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/adder_result_display.sv
// Captures the 4-bit adder result {cout_in, sum_in} and drives a
// time-multiplexed two-digit seven-segment display (ones, tens) with the
// tens digit blanked when zero.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sum_in, cout_in  adder S[2:0] and Cout
//   load             capture strobe, sampled every rising edge
//   value_q          captured result
//   seg              segments {g,f,e,d,c,b,a}
//   an               digit enables, an[0]=ones, an[1]=tens
//   upd              high the cycle after each capture
// Build option: SEG_ACTIVE_LOW_EN inverts seg and an (including reset values)
// for common-anode style boards; default is active-high.
module adder_result_display
  import adder_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sum_in,
  input  logic             cout_in,
  input  logic             load,
  output logic [VAL_W-1:0] value_q,
  output logic [SEG_W-1:0] seg,
  output logic [AN_W-1:0]  an,
  output logic             upd
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [SEG_W-1:0] SEG_POL = 7'h7F;
  localparam logic [AN_W-1:0]  AN_POL  = 2'b11;
`else
  localparam logic [SEG_W-1:0] SEG_POL = 7'h00;
  localparam logic [AN_W-1:0]  AN_POL  = 2'b00;
`endif

  // Refresh period below two cycles cannot alternate digits meaningfully.
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("adder_result_display: REFRESH_DIV must be >= 2");
  end

  logic [VAL_W-1:0] value_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_c;
  digit_e           state_q;
  digit_e           state_d;
  bcd_t             bcd_c;
  logic [DIG_W-1:0] enc_digit_c;
  logic [SEG_W-1:0] enc_seg_c;
  logic [SEG_W-1:0] seg_d;
  logic [AN_W-1:0]  an_d;

  // Next captured value; the output register looks at this so a load is
  // visible on the display at the same edge it is captured.
  assign value_d = load ? {cout_in, sum_in} : value_q;

  // Free-running refresh counter; load never disturbs it.
  assign tick_c = (cnt_q == CNT_MAX);
  assign cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);

  assign bcd_c = to_bcd(value_d);

  // Single encoder shared by both phases; the tens digit can only ever be 1.
  assign enc_digit_c = (state_d == DIG_TENS) ? DIG_W'(1) : bcd_c.ones;

  seg7_encode u_enc (
    .digit (enc_digit_c),
    .seg_c (enc_seg_c)
  );

  // Capture register and update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      upd     <= 1'b0;
    end else begin
      value_q <= value_d;
      upd     <= load;
    end
  end

  // Refresh counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Digit FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIG_ONES;
    end else begin
      state_q <= state_d;
    end
  end

  // Digit FSM next state and display drive for the upcoming digit.
  always_comb begin
    state_d = state_q;
    seg_d   = SEG_BLANK;
    an_d    = AN_NONE;
    case (state_q)
      DIG_ONES: if (tick_c) state_d = DIG_TENS;
      DIG_TENS: if (tick_c) state_d = DIG_ONES;
      default:  state_d = DIG_ONES;
    endcase
    case (state_d)
      DIG_ONES: begin
        seg_d = enc_seg_c;
        an_d  = AN_ONES;
      end
      DIG_TENS: begin
        if (bcd_c.tens) begin
          seg_d = enc_seg_c;
          an_d  = AN_TENS;
        end
      end
      default: begin
        seg_d = SEG_BLANK;
        an_d  = AN_NONE;
      end
    endcase
  end

  // Output register; polarity applied on its input so reset is also "all off".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK ^ SEG_POL;
      an  <= AN_NONE ^ AN_POL;
    end else begin
      seg <= seg_d ^ SEG_POL;
      an  <= an_d ^ AN_POL;
    end
  end

endmodule

// File: tb/tb_adder_result_display.sv
// Self-checking bench for adder_result_display with REFRESH_DIV=4.
// A reference model tracks edges since reset release and the captured value;
// digit phase is derived arithmetically from the edge count. A compare process
// checks every falling edge; directed literal checks pin the model.
module tb_adder_result_display;

  localparam int unsigned DIV = 4;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] SI = 7'h7F;
  localparam logic [1:0] AI = 2'b11;
`else
  localparam logic [6:0] SI = 7'h00;
  localparam logic [1:0] AI = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] sum_in;
  logic       cout_in;
  logic       load;
  logic [3:0] value_q;
  logic [6:0] seg;
  logic [1:0] an;
  logic       upd;

  int errors = 0;
  int checks = 0;

  logic [6:0] enc_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  adder_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sum_in  (sum_in),
    .cout_in (cout_in),
    .load    (load),
    .value_q (value_q),
    .seg     (seg),
    .an      (an),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: edges since release and the most recent captured value.
  int         m_k;
  int         m_val;
  logic       m_upd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k   <= 0;
      m_val <= 0;
      m_upd <= 1'b0;
    end else begin
      m_k   <= m_k + 1;
      if (load) m_val <= int'({cout_in, sum_in});
      m_upd <= load;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [6:0] es;
    logic [1:0] ea;
    int tens, ones, phase;
    if (m_k == 0) begin
      es = 7'h00;
      ea = 2'b00;
    end else begin
      tens  = (m_val >= 10) ? 1 : 0;
      ones  = m_val - 10 * tens;
      phase = (m_k / DIV) % 2;
      if (phase == 0) begin
        es = enc_tab[ones];
        ea = 2'b01;
      end else if (tens == 1) begin
        es = enc_tab[1];
        ea = 2'b10;
      end else begin
        es = 7'h00;
        ea = 2'b00;
      end
    end
    chk("model_value_q", 32'(value_q), 32'(m_val));
    chk("model_upd", 32'(upd), 32'(m_upd));
    chk("model_seg", 32'(seg), 32'(es ^ SI));
    chk("model_an", 32'(an), 32'(ea ^ AI));
  end

  task automatic drive(input logic c, input logic [2:0] s, input logic l);
    cout_in = c;
    sum_in  = s;
    load    = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'(7'h00 ^ SI));
    chk("rst_an", 32'(an), 32'(2'b00 ^ AI));
    chk("rst_value_q", 32'(value_q), 0);
    chk("rst_upd", 32'(upd), 0);
    rst_n = 1'b1;

    @(negedge clk);                         // k=1
    chk("first_an", 32'(an), 32'(2'b01 ^ AI));
    chk("first_seg", 32'(seg), 32'(7'h3F ^ SI));
    repeat (3) @(negedge clk);              // k=4, tens phase, blanked
    chk("blank_an", 32'(an), 32'(2'b00 ^ AI));
    chk("blank_seg", 32'(seg), 32'(7'h00 ^ SI));

    drive(1'b0, 3'b111, 1'b1);
    @(negedge clk);                         // k=5
    chk("ld7_value", 32'(value_q), 7);
    chk("ld7_upd", 32'(upd), 1);
    chk("ld7_tens_an", 32'(an), 32'(2'b00 ^ AI));
    load = 1'b0;
    @(negedge clk);                         // k=6
    chk("ld7_upd_drop", 32'(upd), 0);
    repeat (2) @(negedge clk);              // k=8, ones phase
    chk("ld7_ones_an", 32'(an), 32'(2'b01 ^ AI));
    chk("ld7_ones_seg", 32'(seg), 32'(7'h07 ^ SI));

    drive(1'b1, 3'b110, 1'b1);
    @(negedge clk);                         // k=9
    chk("ld14_value", 32'(value_q), 14);
    chk("ld14_ones_seg", 32'(seg), 32'(7'h66 ^ SI));
    load = 1'b0;
    repeat (3) @(negedge clk);              // k=12, tens phase
    chk("ld14_tens_an", 32'(an), 32'(2'b10 ^ AI));
    chk("ld14_tens_seg", 32'(seg), 32'(7'h06 ^ SI));

    repeat (7) @(negedge clk);              // k=19, ones phase, tick next
    chk("pre_tick_an", 32'(an), 32'(2'b01 ^ AI));
    drive(1'b1, 3'b100, 1'b1);              // 12 on the tick edge
    @(negedge clk);                         // k=20
    chk("tick_ld_an", 32'(an), 32'(2'b10 ^ AI));
    chk("tick_ld_seg", 32'(seg), 32'(7'h06 ^ SI));
    chk("tick_ld_value", 32'(value_q), 12);

    drive(1'b1, 3'b101, 1'b1);              // back-to-back: 13 then 11
    @(negedge clk);                         // k=21
    chk("b2b_value13", 32'(value_q), 13);
    chk("b2b_upd13", 32'(upd), 1);
    drive(1'b1, 3'b011, 1'b1);
    @(negedge clk);                         // k=22
    chk("b2b_value11", 32'(value_q), 11);
    chk("b2b_upd11", 32'(upd), 1);
    drive(1'b1, 3'b111, 1'b1);              // forced 15
    @(negedge clk);                         // k=23
    chk("v15_tens_seg", 32'(seg), 32'(7'h06 ^ SI));
    load = 1'b0;
    @(negedge clk);                         // k=24
    chk("v15_ones_seg", 32'(seg), 32'(7'h6D ^ SI));
    chk("v15_upd", 32'(upd), 0);

    drive(1'b1, 3'b010, 1'b1);              // 10
    @(negedge clk);                         // k=25
    load = 1'b0;
    repeat (3) @(negedge clk);              // k=28, tens phase
    chk("v10_tens_an", 32'(an), 32'(2'b10 ^ AI));
    @(negedge clk);                         // k=29
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", 32'(seg), 32'(7'h00 ^ SI));
    chk("midrst_an", 32'(an), 32'(2'b00 ^ AI));
    chk("midrst_value", 32'(value_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);                         // k=1
    chk("post_rst_an", 32'(an), 32'(2'b01 ^ AI));
    chk("post_rst_seg", 32'(seg), 32'(7'h3F ^ SI));

    drive(1'b1, 3'b001, 1'b1);              // 9
    @(negedge clk);                         // k=2
    chk("v9_ones_seg", 32'(seg), 32'(7'h6F ^ SI));
    chk("v9_ones_an", 32'(an), 32'(2'b01 ^ AI));
    load = 1'b0;

    // Sweep every captureable value through both display phases.
    for (int v = 0; v < 16; v++) begin
      drive(v[3], v[2:0], 1'b1);
      @(negedge clk);
      load = 1'b0;
      repeat (8) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
